// File: rtl/axis_frame_arbiter.sv
// Frame-granular two-source AXI4-Stream arbiter: a source owns the sink from its
// start-of-frame beat until LINES_PER_FRAME TLAST beats have been accepted.
module axis_frame_arbiter #(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int LINES_PER_FRAME    = 1024,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                            M_AXIS_ACLK,
    input  logic                            M_AXIS_ARESETN,

    input  logic                            S0_AXIS_TVALID,
    output logic                            S0_AXIS_TREADY,
    input  logic                            S0_AXIS_TLAST,
    input  logic                            S0_AXIS_TUSER,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   S0_AXIS_TDATA,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] S0_AXIS_TSTRB,

    input  logic                            S1_AXIS_TVALID,
    output logic                            S1_AXIS_TREADY,
    input  logic                            S1_AXIS_TLAST,
    input  logic                            S1_AXIS_TUSER,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   S1_AXIS_TDATA,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] S1_AXIS_TSTRB,

    output logic                            M_AXIS_TVALID,
    input  logic                            M_AXIS_TREADY,
    output logic                            M_AXIS_TLAST,
    output logic                            M_AXIS_TUSER,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,

    input  logic [1:0]                      CFG_EN,
    output logic [1:0]                      GRANT,
    output logic [CNT_WIDTH-1:0]            FRAME_CNT0,
    output logic [CNT_WIDTH-1:0]            FRAME_CNT1,
    output logic [CNT_WIDTH-1:0]            ERR_CNT
);

    localparam int          SW        = C_AXIS_TDATA_WIDTH / 8;
    localparam logic [11:0] LAST_LINE = 12'(LINES_PER_FRAME - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             grant_q;
    logic [11:0]            line_q, line_d;
    logic                   ptr_q, ptr_d;
    logic                   first_q, first_d;
    logic [CNT_WIDTH-1:0]   fcnt0_q, fcnt0_d;
    logic [CNT_WIDTH-1:0]   fcnt1_q, fcnt1_d;
    logic [CNT_WIDTH-1:0]   err_q, err_d;

    logic                   granted;
    logic                   sel;
    logic                   sel_valid;
    logic                   sel_last;
    logic                   sel_user;
    logic [C_AXIS_TDATA_WIDTH-1:0] sel_data;
    logic [SW-1:0]          sel_strb;
    logic                   cand0, cand1;
    logic                   win1;
    logic                   accept;
    logic                   early_sof;
    logic [11:0]            base_line;
    logic                   frame_done;

    assign granted = (state_q != IDLE);
    assign sel     = (state_q == GRANT1);

    always_comb begin
        sel_valid = S0_AXIS_TVALID;
        sel_last  = S0_AXIS_TLAST;
        sel_user  = S0_AXIS_TUSER;
        sel_data  = S0_AXIS_TDATA;
        sel_strb  = S0_AXIS_TSTRB;
        if (sel) begin
            sel_valid = S1_AXIS_TVALID;
            sel_last  = S1_AXIS_TLAST;
            sel_user  = S1_AXIS_TUSER;
            sel_data  = S1_AXIS_TDATA;
            sel_strb  = S1_AXIS_TSTRB;
        end
    end

    // Arbitration looks only at SOF beats; ties go to the priority pointer.
    assign cand0 = CFG_EN[0] & S0_AXIS_TVALID & S0_AXIS_TUSER;
    assign cand1 = CFG_EN[1] & S1_AXIS_TVALID & S1_AXIS_TUSER;
    assign win1  = cand1 & (~cand0 | ptr_q);

    assign accept     = granted & sel_valid & M_AXIS_TREADY;
    assign early_sof  = accept & sel_user & ~first_q;
    assign base_line  = early_sof ? 12'd0 : line_q;
    assign frame_done = accept & sel_last & (base_line == LAST_LINE);

    assign M_AXIS_TVALID = granted & sel_valid;
    assign M_AXIS_TLAST  = granted & sel_last;
    assign M_AXIS_TUSER  = granted & sel_user;
    assign M_AXIS_TDATA  = granted ? sel_data : '0;
    assign M_AXIS_TSTRB  = granted ? sel_strb : '0;

    // In IDLE, enabled non-SOF beats are swallowed so the source resyncs to a frame start.
    assign S0_AXIS_TREADY = (state_q == GRANT0) ? M_AXIS_TREADY
                          : ((state_q == IDLE) & M_AXIS_ARESETN & CFG_EN[0] &
                             S0_AXIS_TVALID & ~S0_AXIS_TUSER);
    assign S1_AXIS_TREADY = (state_q == GRANT1) ? M_AXIS_TREADY
                          : ((state_q == IDLE) & M_AXIS_ARESETN & CFG_EN[1] &
                             S1_AXIS_TVALID & ~S1_AXIS_TUSER);

    assign GRANT      = grant_q;
    assign FRAME_CNT0 = fcnt0_q;
    assign FRAME_CNT1 = fcnt1_q;
    assign ERR_CNT    = err_q;

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        ptr_d   = ptr_q;
        first_d = first_q;
        fcnt0_d = fcnt0_q;
        fcnt1_d = fcnt1_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (cand0 | cand1) begin
                    state_d = win1 ? GRANT1 : GRANT0;
                    line_d  = 12'd0;
                    first_d = 1'b1;
                end
            end
            GRANT0, GRANT1: begin
                if (accept) begin
                    first_d = 1'b0;
                    line_d  = base_line;
                    if (early_sof) begin
                        err_d = err_q + CNT_WIDTH'(1);
                    end
                    if (frame_done) begin
                        line_d  = 12'd0;
                        state_d = IDLE;
                        ptr_d   = ~sel;
                        if (sel) begin
                            fcnt1_d = fcnt1_q + CNT_WIDTH'(1);
                        end else begin
                            fcnt0_d = fcnt0_q + CNT_WIDTH'(1);
                        end
                    end else if (sel_last) begin
                        line_d = base_line + 12'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            line_q  <= 12'd0;
            ptr_q   <= 1'b0;
            first_q <= 1'b0;
            fcnt0_q <= '0;
            fcnt1_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= {state_d == GRANT1, state_d == GRANT0};
            line_q  <= line_d;
            ptr_q   <= ptr_d;
            first_q <= first_d;
            fcnt0_q <= fcnt0_d;
            fcnt1_q <= fcnt1_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Bench for axis_frame_arbiter: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_axis_frame_arbiter;

    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int LPF = 4;
    localparam int CW  = 16;
    localparam int BPL = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]             s_v = '0, s_u = '0, s_l = '0;
    logic [1:0][DW-1:0]     s_d = '0;
    logic [1:0][SW-1:0]     s_k = '0;
    logic                   m_ready = 1'b0;
    logic [1:0]             en = 2'b00, en_next = 2'b00;

    logic                   S0_TREADY, S1_TREADY;
    logic                   M_TVALID, M_TLAST, M_TUSER;
    logic [DW-1:0]          M_TDATA;
    logic [SW-1:0]          M_TSTRB;
    logic [1:0]             GRANT;
    logic [CW-1:0]          FRAME_CNT0, FRAME_CNT1, ERR_CNT;

    axis_frame_arbiter #(
        .C_AXIS_TDATA_WIDTH(DW),
        .LINES_PER_FRAME   (LPF),
        .CNT_WIDTH         (CW)
    ) dut (
        .M_AXIS_ACLK    (clk),
        .M_AXIS_ARESETN (rst_n),
        .S0_AXIS_TVALID (s_v[0]),
        .S0_AXIS_TREADY (S0_TREADY),
        .S0_AXIS_TLAST  (s_l[0]),
        .S0_AXIS_TUSER  (s_u[0]),
        .S0_AXIS_TDATA  (s_d[0]),
        .S0_AXIS_TSTRB  (s_k[0]),
        .S1_AXIS_TVALID (s_v[1]),
        .S1_AXIS_TREADY (S1_TREADY),
        .S1_AXIS_TLAST  (s_l[1]),
        .S1_AXIS_TUSER  (s_u[1]),
        .S1_AXIS_TDATA  (s_d[1]),
        .S1_AXIS_TSTRB  (s_k[1]),
        .M_AXIS_TVALID  (M_TVALID),
        .M_AXIS_TREADY  (m_ready),
        .M_AXIS_TLAST   (M_TLAST),
        .M_AXIS_TUSER   (M_TUSER),
        .M_AXIS_TDATA   (M_TDATA),
        .M_AXIS_TSTRB   (M_TSTRB),
        .CFG_EN         (en),
        .GRANT          (GRANT),
        .FRAME_CNT0     (FRAME_CNT0),
        .FRAME_CNT1     (FRAME_CNT1),
        .ERR_CNT        (ERR_CNT)
    );

    int errors = 0;
    int checks = 0;
    int out_beats = 0;

    // Source generators: each emits frames of LPF lines x BPL beats.
    int line_p [2];
    int beat_p [2];
    int budget [2];
    int restart_at [2];
    int sent [2];
    int seq [2];
    int gap_pct = 0;
    int jump_pct = 0;
    int rdy_mode = 0;
    logic [1:0] hs = '0;

    // Reference model state: owner -1 means nobody holds the sink.
    int             m_own = -1;
    int             m_lines = 0;
    int             m_ptr = 0;
    int             m_win = -1;
    bit             m_first = 1'b0;
    logic [CW-1:0]  m_fc [2];
    logic [CW-1:0]  m_err = '0;

    logic           e_mv, e_ml, e_mu;
    logic [DW-1:0]  e_md;
    logic [SW-1:0]  e_mk;
    logic [1:0]     e_rdy, e_gnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic src_cfg(input int i, input int ln, input int bt, input int bud, input int rst_at);
        line_p[i] = ln;
        beat_p[i] = bt;
        budget[i] = bud;
        restart_at[i] = rst_at;
        sent[i] = 0;
    endtask

    task automatic drive_src(input int i);
        if (hs[i]) begin
            sent[i]++;
            seq[i]++;
            if (budget[i] > 0) budget[i]--;
            beat_p[i]++;
            if (beat_p[i] == BPL) begin
                beat_p[i] = 0;
                line_p[i] = (line_p[i] + 1) % LPF;
            end
            if (sent[i] == restart_at[i]) begin
                line_p[i] = 0;
                beat_p[i] = 0;
            end
        end
        if (s_v[i] && !hs[i]) return;
        s_v[i] = 1'b0;
        if (budget[i] == 0) return;
        if (int'($urandom_range(99)) < gap_pct) return;
        if (int'($urandom_range(99)) < jump_pct) begin
            line_p[i] = int'($urandom_range(LPF - 1));
            beat_p[i] = int'($urandom_range(BPL - 1));
        end
        s_v[i] = 1'b1;
        s_u[i] = (line_p[i] == 0) && (beat_p[i] == 0);
        s_l[i] = (beat_p[i] == BPL - 1);
        s_d[i] = {i[3:0], 12'h000, seq[i][15:0]};
        s_k[i] = SW'($urandom);
    endtask

    task automatic model_reset();
        m_own = -1;
        m_lines = 0;
        m_ptr = 0;
        m_win = -1;
        m_first = 1'b0;
        m_fc[0] = '0;
        m_fc[1] = '0;
        m_err = '0;
    endtask

    task automatic model_outputs();
        bit c0, c1;
        e_rdy = '0; e_gnt = '0; e_mv = 1'b0; e_ml = 1'b0; e_mu = 1'b0; e_md = '0; e_mk = '0;
        m_win = -1;
        if (m_own < 0) begin
            c0 = en[0] && s_v[0] && s_u[0];
            c1 = en[1] && s_v[1] && s_u[1];
            if (c0 && c1) m_win = m_ptr;
            else if (c0) m_win = 0;
            else if (c1) m_win = 1;
            for (int i = 0; i < 2; i++)
                if (en[i] && s_v[i] && !s_u[i]) e_rdy[i] = 1'b1;
        end else begin
            e_gnt[m_own] = 1'b1;
            e_mv = s_v[m_own];
            e_ml = s_l[m_own];
            e_mu = s_u[m_own];
            e_md = s_d[m_own];
            e_mk = s_k[m_own];
            e_rdy[m_own] = m_ready;
        end
    endtask

    // Frame rules: count lines on accepted TLAST, restart on a late SOF, release on the last line.
    task automatic model_step();
        int k;
        if (m_own < 0) begin
            if (m_win >= 0) begin
                m_own = m_win;
                m_first = 1'b1;
                m_lines = 0;
            end
        end else if (s_v[m_own] && m_ready) begin
            k = m_own;
            if (s_u[k] && !m_first) begin
                m_err = m_err + 1'b1;
                m_lines = 0;
            end
            m_first = 1'b0;
            if (s_l[k]) begin
                if (m_lines == LPF - 1) begin
                    m_fc[k] = m_fc[k] + 1'b1;
                    m_lines = 0;
                    m_ptr = 1 - k;
                    m_own = -1;
                end else begin
                    m_lines++;
                end
            end
        end
    endtask

    task automatic compare();
        model_outputs();
        chk("grant", GRANT, e_gnt);
        chk("m_tvalid", M_TVALID, e_mv);
        if (e_mv) begin
            chk("m_tdata", M_TDATA, e_md);
            chk("m_tstrb", M_TSTRB, e_mk);
            chk("m_tlast", M_TLAST, e_ml);
            chk("m_tuser", M_TUSER, e_mu);
        end
        chk("s0_tready", S0_TREADY, e_rdy[0]);
        chk("s1_tready", S1_TREADY, e_rdy[1]);
        chk("frame_cnt0", FRAME_CNT0, m_fc[0]);
        chk("frame_cnt1", FRAME_CNT1, m_fc[1]);
        chk("err_cnt", ERR_CNT, m_err);
        hs = s_v & {S1_TREADY, S0_TREADY};
        if (M_TVALID && m_ready) out_beats++;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        en = en_next;
        drive_src(0);
        drive_src(1);
        case (rdy_mode)
            1:       m_ready = ~m_ready;
            2:       m_ready = ($urandom_range(3) != 0);
            default: m_ready = 1'b1;
        endcase
        #2;
        compare();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_v = '0;
        hs = '0;
        m_ready = 1'b0;
        out_beats = 0;
        gap_pct = 0;
        jump_pct = 0;
        rdy_mode = 0;
        model_reset();
        src_cfg(0, 0, 0, 0, -1);
        src_cfg(1, 0, 0, 0, -1);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_grant", GRANT, 2'b00);
        chk("rst_m_tvalid", M_TVALID, 1'b0);
        chk("rst_m_tdata", M_TDATA, '0);
        chk("rst_m_tstrb", M_TSTRB, '0);
        chk("rst_m_tlast_tuser", {M_TLAST, M_TUSER}, 2'b00);
        chk("rst_treadys", {S1_TREADY, S0_TREADY}, 2'b00);
        chk("rst_counters", {FRAME_CNT0, FRAME_CNT1, ERR_CNT}, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        seq[0] = 0;
        seq[1] = 0;
        model_reset();

        // Single source, one clean frame.
        do_reset();
        en_next = 2'b01;
        src_cfg(0, 0, 0, 12, -1);
        run(20);
        chk("t1_frame_cnt0", FRAME_CNT0, 16'd1);
        chk("t1_err_cnt", ERR_CNT, 16'd0);
        chk("t1_out_beats", out_beats, 12);
        chk("t1_grant_idle", GRANT, 2'b00);

        // Simultaneous SOF: pointer 0 picks source 0, then source 1.
        do_reset();
        en_next = 2'b11;
        src_cfg(0, 0, 0, 12, -1);
        src_cfg(1, 0, 0, 12, -1);
        run(2);
        chk("t2_first_grant", GRANT, 2'b01);
        run(30);
        chk("t2_frame_cnt0", FRAME_CNT0, 16'd1);
        chk("t2_frame_cnt1", FRAME_CNT1, 16'd1);
        chk("t2_out_beats", out_beats, 24);

        // Source 1 joins mid-frame: 9 beats dropped, then one frame.
        do_reset();
        en_next = 2'b10;
        src_cfg(1, 1, 0, 21, -1);
        run(30);
        chk("t3_frame_cnt1", FRAME_CNT1, 16'd1);
        chk("t3_out_beats", out_beats, 12);

        // Sink back-pressure toggling.
        do_reset();
        en_next = 2'b01;
        rdy_mode = 1;
        src_cfg(0, 0, 0, 12, -1);
        run(40);
        chk("t4_frame_cnt0", FRAME_CNT0, 16'd1);
        chk("t4_out_beats", out_beats, 12);

        // Early SOF after two lines: one error, then a full frame.
        do_reset();
        en_next = 2'b01;
        src_cfg(0, 0, 0, 18, 6);
        run(30);
        chk("t5_err_cnt", ERR_CNT, 16'd1);
        chk("t5_frame_cnt0", FRAME_CNT0, 16'd1);
        chk("t5_out_beats", out_beats, 18);

        // Async reset in the middle of a source-1 frame.
        do_reset();
        en_next = 2'b11;
        src_cfg(0, 0, 0, 12, -1);
        src_cfg(1, 0, 0, 12, -1);
        run(18);
        chk("t6_grant_before", GRANT, 2'b10);
        chk("t6_frame_cnt0_before", FRAME_CNT0, 16'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_m_tvalid", M_TVALID, 1'b0);
        chk("t6_async_grant", GRANT, 2'b00);
        chk("t6_async_counters", {FRAME_CNT0, FRAME_CNT1, ERR_CNT}, '0);
        chk("t6_async_s1_tready", S1_TREADY, 1'b0);
        do_reset();
        en_next = 2'b11;
        src_cfg(0, 0, 0, 12, -1);
        src_cfg(1, 0, 0, 12, -1);
        run(2);
        chk("t6_regrant_ptr0", GRANT, 2'b01);

        // Randomized soak: gaps, jumps, random back-pressure and enable changes.
        do_reset();
        en_next = 2'b11;
        gap_pct = 20;
        jump_pct = 4;
        rdy_mode = 2;
        src_cfg(0, 0, 0, -1, -1);
        src_cfg(1, int'($urandom_range(LPF - 1)), 0, -1, -1);
        for (int blk = 0; blk < 80; blk++) begin
            run(50);
            en_next = 2'($urandom_range(3));
            if (en_next == 2'b00) en_next = 2'b11;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
